// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - trap controller state encoding and standard RISC-V cause codes
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAP   = 2'd1,
    RETURN = 2'd2
  } trap_state_e;

  localparam int EXC_IAM     = 0;
  localparam int EXC_IAF     = 1;
  localparam int EXC_II      = 2;
  localparam int EXC_LAM     = 4;
  localparam int EXC_LAF     = 5;
  localparam int EXC_SAM     = 6;
  localparam int EXC_SAF     = 7;
  localparam int EXC_ECALL_U = 8;
  localparam int EXC_ECALL_S = 9;
  localparam int EXC_ECALL_M = 11;

  localparam int IRQ_SSI = 1;
  localparam int IRQ_MSI = 3;
  localparam int IRQ_STI = 5;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_SEI = 9;
  localparam int IRQ_MEI = 11;

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - parametrised priority encoder, LSB-first or MSB-first
module trap_prio_enc #(
  parameter int WIDTH     = 16,
  parameter int CODE_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0]  req_i,
  output logic [CODE_W-1:0] code_o,
  output logic              hit_o
);

  // Scan so that the winning index is the last one written.
  always_comb begin
    code_o = '0;
    hit_o  = |req_i;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req_i[i]) code_o = CODE_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req_i[i]) code_o = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry/return controller with redirect handshake
// Optional macro TRAP_VECTORED_EN: vectored interrupt targets when MTVEC mode is 2'b01.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_EXC = 16,
  parameter int NUM_IRQ = 12,
  parameter int CODE_W  = $clog2((NUM_EXC > NUM_IRQ) ? NUM_EXC : NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_EXC-1:0] EXC_VALID,
  input  logic [XLEN-1:0]    EXC_PC,
  input  logic [XLEN-1:0]    EXC_TVAL,
  input  logic [NUM_IRQ-1:0] IRQ_PEND,
  input  logic [NUM_IRQ-1:0] IRQ_EN,
  input  logic               GIE,
  input  logic               RET_INST,
  input  logic [XLEN-1:0]    MTVEC,
  input  logic               REDIRECT_READY,
  output logic               REDIRECT_VALID,
  output logic [XLEN-1:0]    REDIRECT_PC,
  output logic               FLUSH,
  output logic [XLEN-1:0]    CAUSE,
  output logic [XLEN-1:0]    EPC,
  output logic [XLEN-1:0]    TVAL,
  output logic               IE_CLR,
  output logic               IE_RESTORE,
  output logic               BUSY
);

  trap_state_e       state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;
  logic              flush_q, flush_d;
  logic              ie_clr_q, ie_clr_d;
  logic              ie_restore_q, ie_restore_d;

  logic [CODE_W-1:0] exc_code, irq_code;
  logic              exc_hit, irq_hit;
  logic [XLEN-1:0]   vec_base, irq_pc;

  trap_prio_enc #(.WIDTH(NUM_EXC), .CODE_W(CODE_W), .MSB_FIRST(1'b0)) u_exc_enc (
    .req_i  (EXC_VALID),
    .code_o (exc_code),
    .hit_o  (exc_hit)
  );

  trap_prio_enc #(.WIDTH(NUM_IRQ), .CODE_W(CODE_W), .MSB_FIRST(1'b1)) u_irq_enc (
    .req_i  (IRQ_PEND & IRQ_EN),
    .code_o (irq_code),
    .hit_o  (irq_hit)
  );

  assign vec_base = {MTVEC[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign irq_pc = (MTVEC[1:0] == 2'b01) ? (vec_base + (XLEN'(irq_code) << 2)) : vec_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^MTVEC[1:0];
  assign irq_pc = vec_base;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      epc_q        <= '0;
      tval_q       <= '0;
      rpc_q        <= '0;
      flush_q      <= 1'b0;
      ie_clr_q     <= 1'b0;
      ie_restore_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      tval_q       <= tval_d;
      rpc_q        <= rpc_d;
      flush_q      <= flush_d;
      ie_clr_q     <= ie_clr_d;
      ie_restore_q <= ie_restore_d;
    end
  end

  // Pulses are only raised on the IDLE exit edge, so they last one cycle.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    tval_d       = tval_q;
    rpc_d        = rpc_q;
    flush_d      = 1'b0;
    ie_clr_d     = 1'b0;
    ie_restore_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_hit) begin
          cause_d  = XLEN'(exc_code);
          epc_d    = EXC_PC;
          tval_d   = EXC_TVAL;
          rpc_d    = vec_base;
          flush_d  = 1'b1;
          ie_clr_d = 1'b1;
          state_d  = TRAP;
        end else if (GIE && irq_hit) begin
          cause_d           = XLEN'(irq_code);
          cause_d[XLEN-1]   = 1'b1;
          epc_d             = EXC_PC;
          tval_d            = '0;
          rpc_d             = irq_pc;
          flush_d           = 1'b1;
          ie_clr_d          = 1'b1;
          state_d           = TRAP;
        end else if (RET_INST) begin
          rpc_d        = epc_q;
          flush_d      = 1'b1;
          ie_restore_d = 1'b1;
          state_d      = RETURN;
        end
      end
      TRAP, RETURN: begin
        if (REDIRECT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY           = (state_q != IDLE);
  assign REDIRECT_VALID = BUSY;
  assign REDIRECT_PC    = rpc_q;
  assign FLUSH          = flush_q;
  assign IE_CLR         = ie_clr_q;
  assign IE_RESTORE     = ie_restore_q;
  assign CAUSE          = cause_q;
  assign EPC            = epc_q;
  assign TVAL           = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;
  import trap_pkg::*;

  localparam int XLEN    = 64;
  localparam int NUM_EXC = 16;
  localparam int NUM_IRQ = 12;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [NUM_EXC-1:0] EXC_VALID;
  logic [XLEN-1:0]    EXC_PC;
  logic [XLEN-1:0]    EXC_TVAL;
  logic [NUM_IRQ-1:0] IRQ_PEND;
  logic [NUM_IRQ-1:0] IRQ_EN;
  logic               GIE;
  logic               RET_INST;
  logic [XLEN-1:0]    MTVEC;
  logic               REDIRECT_READY;
  logic               REDIRECT_VALID;
  logic [XLEN-1:0]    REDIRECT_PC;
  logic               FLUSH;
  logic [XLEN-1:0]    CAUSE;
  logic [XLEN-1:0]    EPC;
  logic [XLEN-1:0]    TVAL;
  logic               IE_CLR;
  logic               IE_RESTORE;
  logic               BUSY;

  int tests  = 0;
  int failed = 0;

  trap_ctrl #(.XLEN(XLEN), .NUM_EXC(NUM_EXC), .NUM_IRQ(NUM_IRQ)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .EXC_VALID      (EXC_VALID),
    .EXC_PC         (EXC_PC),
    .EXC_TVAL       (EXC_TVAL),
    .IRQ_PEND       (IRQ_PEND),
    .IRQ_EN         (IRQ_EN),
    .GIE            (GIE),
    .RET_INST       (RET_INST),
    .MTVEC          (MTVEC),
    .REDIRECT_READY (REDIRECT_READY),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .FLUSH          (FLUSH),
    .CAUSE          (CAUSE),
    .EPC            (EPC),
    .TVAL           (TVAL),
    .IE_CLR         (IE_CLR),
    .IE_RESTORE     (IE_RESTORE),
    .BUSY           (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"},   64'(REDIRECT_VALID), 64'd0);
    check({tag, " rpc"},     REDIRECT_PC,         64'd0);
    check({tag, " flush"},   64'(FLUSH),          64'd0);
    check({tag, " cause"},   CAUSE,               64'd0);
    check({tag, " epc"},     EPC,                 64'd0);
    check({tag, " tval"},    TVAL,                64'd0);
    check({tag, " ie_clr"},  64'(IE_CLR),         64'd0);
    check({tag, " ie_rst"},  64'(IE_RESTORE),     64'd0);
    check({tag, " busy"},    64'(BUSY),           64'd0);
  endtask

  initial begin
    RESET = 1'b1; EXC_VALID = '0; EXC_PC = '0; EXC_TVAL = '0;
    IRQ_PEND = '0; IRQ_EN = '0; GIE = 1'b0; RET_INST = 1'b0;
    MTVEC = '0; REDIRECT_READY = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    RESET = 1'b0;

    // Exception: bits 4 and 5 set, lowest (LAM) wins
    EXC_VALID = 16'h0030; EXC_PC = 64'h1000; EXC_TVAL = 64'hDEAD;
    MTVEC = 64'h8000; REDIRECT_READY = 1'b1;
    tick();
    EXC_VALID = '0;
    check("exc cause", CAUSE, 64'(EXC_LAM));
    check("exc epc",   EPC,   64'h1000);
    check("exc tval",  TVAL,  64'hDEAD);
    check("exc rpc",   REDIRECT_PC, 64'h8000);
    check("exc flush", 64'(FLUSH), 64'd1);
    check("exc ieclr", 64'(IE_CLR), 64'd1);
    check("exc valid", 64'(REDIRECT_VALID), 64'd1);
    tick();
    check("exc done busy",  64'(BUSY), 64'd0);
    check("exc done flush", 64'(FLUSH), 64'd0);
    check("exc done ieclr", 64'(IE_CLR), 64'd0);

    // Interrupt: lines 7 and 11 pending, highest (MEI) wins
    IRQ_PEND = 12'h880; IRQ_EN = 12'h880; GIE = 1'b1;
    EXC_PC = 64'h2000; EXC_TVAL = 64'hBEEF;
    tick();
    check("irq cause", CAUSE, 64'h8000_0000_0000_000B);
    check("irq tval",  TVAL,  64'd0);
    check("irq epc",   EPC,   64'h2000);
    check("irq ieclr", 64'(IE_CLR), 64'd1);
    tick();
    check("irq done busy", 64'(BUSY), 64'd0);
    GIE = 1'b0;
    tick();
    check("gie0 busy",  64'(BUSY), 64'd0);
    check("gie0 flush", 64'(FLUSH), 64'd0);
    check("gie0 cause", CAUSE, 64'h8000_0000_0000_000B);
    IRQ_PEND = '0; IRQ_EN = '0;

    // Exception beats RET and IRQ; later events ignored while busy
    EXC_VALID = 16'h0004; RET_INST = 1'b1; IRQ_PEND = 12'h080; IRQ_EN = 12'h080;
    GIE = 1'b1; REDIRECT_READY = 1'b0; EXC_PC = 64'h1000; EXC_TVAL = 64'h55;
    tick();
    check("prio cause", CAUSE, 64'(EXC_II));
    check("prio ierst", 64'(IE_RESTORE), 64'd0);
    check("prio busy",  64'(BUSY), 64'd1);
    EXC_VALID = 16'h0001; EXC_PC = 64'h3000;
    tick();
    check("busy ign cause", CAUSE, 64'(EXC_II));
    check("busy ign epc",   EPC, 64'h1000);
    check("busy ign rpc",   REDIRECT_PC, 64'h8000);
    check("busy ign flush", 64'(FLUSH), 64'd0);
    check("busy ign valid", 64'(REDIRECT_VALID), 64'd1);
    EXC_VALID = '0; RET_INST = 1'b0; IRQ_PEND = '0; IRQ_EN = '0; GIE = 1'b0;
    REDIRECT_READY = 1'b1;
    tick();
    check("prio done busy", 64'(BUSY), 64'd0);

    // Return with fetch stalling for three cycles
    RET_INST = 1'b1; REDIRECT_READY = 1'b0; MTVEC = 64'h9000;
    tick();
    RET_INST = 1'b0;
    check("ret rpc",   REDIRECT_PC, 64'h1000);
    check("ret valid", 64'(REDIRECT_VALID), 64'd1);
    check("ret flush", 64'(FLUSH), 64'd1);
    check("ret ierst", 64'(IE_RESTORE), 64'd1);
    check("ret ieclr", 64'(IE_CLR), 64'd0);
    check("ret cause", CAUSE, 64'(EXC_II));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ret stall valid", 64'(REDIRECT_VALID), 64'd1);
      check("ret stall rpc",   REDIRECT_PC, 64'h1000);
      check("ret stall ierst", 64'(IE_RESTORE), 64'd0);
      check("ret stall flush", 64'(FLUSH), 64'd0);
    end
    REDIRECT_READY = 1'b1;
    tick();
    check("ret done busy",  64'(BUSY), 64'd0);
    check("ret done valid", 64'(REDIRECT_VALID), 64'd0);
    check("ret done epc",   EPC, 64'h1000);

    // Reset while stalled in TRAP
    EXC_VALID = 16'h0020; REDIRECT_READY = 1'b0; MTVEC = 64'h8000;
    tick();
    EXC_VALID = '0;
    check("pre-reset busy",  64'(BUSY), 64'd1);
    check("pre-reset cause", CAUSE, 64'(EXC_LAF));
    RESET = 1'b1;
    tick();
    check_all_zero("midreset");
    RESET = 1'b0;
    tick();
    check_all_zero("postreset");

    // Vector mode: interrupt and exception targets
    MTVEC = 64'h8001; REDIRECT_READY = 1'b1;
    IRQ_PEND = 12'h080; IRQ_EN = 12'h080; GIE = 1'b1;
    tick();
    IRQ_PEND = '0; GIE = 1'b0;
    check("vec irq cause", CAUSE, 64'h8000_0000_0000_0000 | 64'(IRQ_MTI));
`ifdef TRAP_VECTORED_EN
    check("vec irq rpc", REDIRECT_PC, 64'h801C);
`else
    check("vec irq rpc", REDIRECT_PC, 64'h8000);
`endif
    tick();
    EXC_VALID = 16'h0020;
    tick();
    EXC_VALID = '0;
    check("vec exc cause", CAUSE, 64'(EXC_LAF));
    check("vec exc rpc",   REDIRECT_PC, 64'h8000);
    tick();
    check("vec done busy", 64'(BUSY), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
